// File: rtl/logic_op_pipe_if.sv
// Operand/result handshake bundle for logic_op_pipe.
// master = operand source + result consumer, slave = the pipe.
interface logic_op_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_op;
    logic             in_acc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_par;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, in_op, in_acc, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_par, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_acc, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_par, out_err
    );
endinterface

// File: rtl/logic_op_pipe.sv
// Registered ten-op bitwise unit with valid/ready handshake,
// accumulator feedback and a saturating transaction counter.
module logic_op_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    logic_op_pipe_if.slave   bus,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] acc_q,
    output logic [CNT_W-1:0] txn_cnt
);
    logic             vld_q;
    logic [WIDTH-1:0] data_q;
    logic             zero_q;
    logic             par_q;
    logic             err_q;

    logic             ready;
    logic             accept;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             err;

    assign ready  = !vld_q || bus.out_ready;
    assign accept = bus.in_valid && ready;
    assign opa    = bus.in_acc ? acc_q : bus.in_a;
    assign opb    = bus.in_b;

    always_comb begin
        res = '0;
        err = 1'b0;
        case (bus.in_op)
            4'd0:    res = opa & opb;
            4'd1:    res = opa | opb;
            4'd2:    res = opa ^ opb;
            4'd3:    res = ~(opa & opb);
            4'd4:    res = ~(opa | opb);
            4'd5:    res = ~(opa ^ opb);
            4'd6:    res = ~opa;
            4'd7:    res = ~opb;
            4'd8:    res = opa;
            4'd9:    res = opb;
            default: err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b1;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
            acc_q   <= '0;
            txn_cnt <= '0;
        end else begin
            if (accept) begin
                vld_q  <= 1'b1;
                data_q <= res;
                zero_q <= (res == '0);
                par_q  <= ^res;
                err_q  <= err;
            end else if (bus.out_ready) begin
                vld_q  <= 1'b0;
            end
            // clear wins, but the op above already saw the old value
            if (acc_clr)
                acc_q <= '0;
            else if (accept)
                acc_q <= res;
            if (accept && txn_cnt != '1)
                txn_cnt <= txn_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = vld_q;
    assign bus.out_data  = data_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_par   = par_q;
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed bench for logic_op_pipe: op table, errors, stall,
// accumulator, counter saturation and async reset.
module tb_logic_op_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       acc_clr = 1'b0;
    logic       acc_clr2 = 1'b0;
    logic [7:0] acc_q;
    logic [7:0] txn_cnt;
    logic [7:0] acc_q2;
    logic [1:0] txn_cnt2;

    int n_run  = 0;
    int n_fail = 0;

    logic_op_pipe_if #(.WIDTH(8)) ifa ();
    logic_op_pipe_if #(.WIDTH(8)) ifb ();

    logic_op_pipe #(.WIDTH(8), .CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (ifa),
        .acc_clr (acc_clr),
        .acc_q   (acc_q),
        .txn_cnt (txn_cnt)
    );

    logic_op_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (ifb),
        .acc_clr (acc_clr2),
        .acc_q   (acc_q2),
        .txn_cnt (txn_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] op,
                         input logic acc);
        @(negedge clk);
        ifa.in_valid = v;
        ifa.in_a     = a;
        ifa.in_b     = b;
        ifa.in_op    = op;
        ifa.in_acc   = acc;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp1 [10];

    initial begin
        exp1 = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03,
                 8'h33, 8'h0F, 8'hC3, 8'hF0, 8'h3C};
        ifa.in_valid = 0; ifa.in_a = 0; ifa.in_b = 0;
        ifa.in_op = 0; ifa.in_acc = 0; ifa.out_ready = 1;
        ifb.in_valid = 0; ifb.in_a = 0; ifb.in_b = 0;
        ifb.in_op = 0; ifb.in_acc = 0; ifb.out_ready = 1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", ifa.out_valid, 0);
        check("rst_data", ifa.out_data, 0);
        check("rst_zero", ifa.out_zero, 1);
        check("rst_par", ifa.out_par, 0);
        check("rst_err", ifa.out_err, 0);
        check("rst_acc", acc_q, 0);
        check("rst_cnt", txn_cnt, 0);
        check("rst_ready", ifa.in_ready, 1);
        @(negedge clk);
        rst_n = 1;

        // all ten ops back to back
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'hF0, 8'h3C, 4'(i), 0);
            step();
            check($sformatf("op%0d_data", i), ifa.out_data, exp1[i]);
            check($sformatf("op%0d_valid", i), ifa.out_valid, 1);
        end
        check("op_err", ifa.out_err, 0);
        check("op_par", ifa.out_par, 0);
        check("op_cnt", txn_cnt, 10);

        // illegal opcode
        drive(1, 8'hFF, 8'hFF, 4'd12, 0);
        step();
        check("ill_data", ifa.out_data, 0);
        check("ill_err", ifa.out_err, 1);
        check("ill_zero", ifa.out_zero, 1);
        check("ill_acc", acc_q, 0);
        check("ill_cnt", txn_cnt, 11);

        // drain: valid falls with no new accept
        drive(0, 0, 0, 0, 0);
        step();
        check("drain_valid", ifa.out_valid, 0);

        // stall
        @(negedge clk);
        ifa.out_ready = 0;
        drive(1, 8'hAA, 8'h00, 4'd8, 0);
        step();
        check("stl_data0", ifa.out_data, 8'hAA);
        drive(1, 8'h55, 8'h00, 4'd8, 0);
        #1;
        check("stl_ready", ifa.in_ready, 0);
        step();
        check("stl_hold", ifa.out_data, 8'hAA);
        check("stl_hvld", ifa.out_valid, 1);
        @(negedge clk);
        ifa.out_ready = 1;
        #1;
        check("stl_rel_rdy", ifa.in_ready, 1);
        step();
        check("stl_data1", ifa.out_data, 8'h55);
        check("stl_cnt", txn_cnt, 13);

        // accumulator
        drive(1, 8'h0F, 8'h00, 4'd8, 0);
        step();
        check("acc_d0", ifa.out_data, 8'h0F);
        check("acc_q0", acc_q, 8'h0F);
        drive(1, 8'h00, 8'hFF, 4'd2, 1);
        step();
        check("acc_d1", ifa.out_data, 8'hF0);
        check("acc_q1", acc_q, 8'hF0);
        drive(1, 8'h00, 8'h01, 4'd1, 1);
        acc_clr = 1;
        step();
        check("acc_d2", ifa.out_data, 8'hF1);
        check("acc_par", ifa.out_par, 1);
        check("acc_q2", acc_q, 8'h00);
        acc_clr = 0;
        drive(1, 8'h5A, 8'h00, 4'd8, 0);
        step();
        check("acc_q3", acc_q, 8'h5A);
        drive(0, 0, 0, 0, 0);
        acc_clr = 1;
        step();
        acc_clr = 0;
        check("clr_only_acc", acc_q, 0);
        check("clr_only_data", ifa.out_data, 8'h5A);
        check("clr_only_vld", ifa.out_valid, 0);

        // saturating 2-bit counter
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ifb.in_valid = 1;
            ifb.in_a = 8'(i);
            ifb.in_op = 4'd8;
            step();
            check($sformatf("sat%0d", i), txn_cnt2, (i < 3) ? i + 1 : 3);
        end
        @(negedge clk);
        ifb.in_valid = 0;

        // async reset while stalled
        @(negedge clk);
        ifa.out_ready = 0;
        drive(1, 8'h77, 8'h00, 4'd8, 0);
        step();
        check("ar_pre_vld", ifa.out_valid, 1);
        check("ar_pre_acc", acc_q, 8'h77);
        ifa.in_valid = 0;
        #2;
        rst_n = 0;
        #1;
        check("ar_vld", ifa.out_valid, 0);
        check("ar_acc", acc_q, 0);
        check("ar_cnt", txn_cnt, 0);
        check("ar_data", ifa.out_data, 0);
        @(negedge clk);
        rst_n = 1;
        step();
        check("ar_ready", ifa.in_ready, 1);
        check("ar_vld2", ifa.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
